// File: rtl/pp_chan_pkg.sv
// Shared constants and helpers for the N-bank ping-pong channel.
// Bank/word index composition and pointer wrap live here so every user agrees on them.
package pp_chan_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefDepth     = 16;
    localparam int unsigned DefAddrWidth = 4;
    localparam int unsigned DefNumBufs   = 2;

    // Advance a bank pointer, wrapping from num_bufs-1 back to 0.
    function automatic int unsigned ptr_next(input int unsigned ptr,
                                             input int unsigned num_bufs);
        return (ptr >= num_bufs - 1) ? 0 : ptr + 1;
    endfunction

    // Flat RAM index of word addr in bank: conceptually {bank, addr} over depth words per bank.
    function automatic int unsigned bank_addr(input int unsigned bank,
                                              input int unsigned addr,
                                              input int unsigned depth);
        return bank * depth + addr;
    endfunction

endpackage

// File: rtl/pp_chan_mem.sv
// Flat synchronous RAM: one read/write port and two read-only ports, all with
// registered outputs that hold while their enable is low and reset to zero.
module pp_chan_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ENTRIES    = 32,
    parameter int unsigned IDX_WIDTH  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_WIDTH-1:0]  a_idx_i,
    input  logic                  a_ce_i,
    input  logic                  a_we_i,
    input  logic [DATA_WIDTH-1:0] a_d_i,
    output logic [DATA_WIDTH-1:0] a_q_o,
    input  logic [IDX_WIDTH-1:0]  b_idx_i,
    input  logic                  b_ce_i,
    output logic [DATA_WIDTH-1:0] b_q_o,
    input  logic [IDX_WIDTH-1:0]  c_idx_i,
    input  logic                  c_ce_i,
    output logic [DATA_WIDTH-1:0] c_q_o
);

    logic [DATA_WIDTH-1:0] mem_q [ENTRIES];
    logic [DATA_WIDTH-1:0] a_q_q;
    logic [DATA_WIDTH-1:0] b_q_q;
    logic [DATA_WIDTH-1:0] c_q_q;

    // Storage is deliberately not reset; a reset only discards bank ownership.
    always_ff @(posedge clk_i) begin
        if (a_ce_i && a_we_i) begin
            mem_q[a_idx_i] <= a_d_i;
        end
    end

    // Read-before-write: port a returns the word as it was before this cycle's write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q_q <= '0;
            b_q_q <= '0;
            c_q_q <= '0;
        end else begin
            if (a_ce_i) begin
                a_q_q <= mem_q[a_idx_i];
            end
            if (b_ce_i) begin
                b_q_q <= mem_q[b_idx_i];
            end
            if (c_ce_i) begin
                c_q_q <= mem_q[c_idx_i];
            end
        end
    end

    assign a_q_o = a_q_q;
    assign b_q_o = b_q_q;
    assign c_q_o = c_q_q;

endmodule

// File: rtl/pp_chan_nbuf.sv
// N-bank ping-pong channel: producer fills bank iptr, consumer reads bank tptr.
// Define PP_CHAN_ERR_EN to add the sticky err output for dropped commits/releases.
module pp_chan_nbuf
    import pp_chan_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned DEPTH      = DefDepth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned NUM_BUFS   = DefNumBufs,
    parameter int unsigned CNT_WIDTH  = $clog2(NUM_BUFS + 1)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [ADDR_WIDTH-1:0] i_address0,
    input  logic                  i_ce0,
    input  logic                  i_we0,
    input  logic [DATA_WIDTH-1:0] i_d0,
    output logic [DATA_WIDTH-1:0] i_q0,
    input  logic                  i_write,
    output logic                  i_full_n,
    input  logic [ADDR_WIDTH-1:0] t_address0,
    input  logic                  t_ce0,
    input  logic [ADDR_WIDTH-1:0] t_address1,
    input  logic                  t_ce1,
    output logic [DATA_WIDTH-1:0] t_q0,
    output logic [DATA_WIDTH-1:0] t_q1,
    input  logic                  t_read,
    output logic                  t_empty_n,
    output logic [CNT_WIDTH-1:0]  occupancy
`ifdef PP_CHAN_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int unsigned PtrWidth = $clog2(NUM_BUFS);
    localparam int unsigned Entries  = NUM_BUFS * DEPTH;
    localparam int unsigned IdxWidth = $clog2(Entries);

    logic [PtrWidth-1:0]  iptr_q, iptr_d;
    logic [PtrWidth-1:0]  tptr_q, tptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 full_n_q, full_n_d;
    logic                 empty_n_q, empty_n_d;
    logic                 commit;
    logic                 release_bank;
    logic [IdxWidth-1:0]  i_idx;
    logic [IdxWidth-1:0]  t_idx0;
    logic [IdxWidth-1:0]  t_idx1;

    assign commit       = i_write & full_n_q;
    assign release_bank = t_read & empty_n_q;

    always_comb begin
        iptr_d  = iptr_q;
        tptr_d  = tptr_q;
        count_d = count_q;
        if (commit) begin
            iptr_d = PtrWidth'(ptr_next(32'(iptr_q), NUM_BUFS));
        end
        if (release_bank) begin
            tptr_d = PtrWidth'(ptr_next(32'(tptr_q), NUM_BUFS));
        end
        unique case ({commit, release_bank})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
        // Flags are registered from the next count so a commit is visible at its own edge.
        full_n_d  = (count_d != CNT_WIDTH'(NUM_BUFS));
        empty_n_d = (count_d != '0);
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            iptr_q    <= '0;
            tptr_q    <= '0;
            count_q   <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
        end else begin
            iptr_q    <= iptr_d;
            tptr_q    <= tptr_d;
            count_q   <= count_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
        end
    end

    assign i_full_n  = full_n_q;
    assign t_empty_n = empty_n_q;
    assign occupancy = count_q;

`ifdef PP_CHAN_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (i_write & ~full_n_q) | (t_read & ~empty_n_q);
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    // Accesses use the pointer of the current cycle, so a read alongside t_read hits the old bank.
    assign i_idx  = IdxWidth'(bank_addr(32'(iptr_q), 32'(i_address0), DEPTH));
    assign t_idx0 = IdxWidth'(bank_addr(32'(tptr_q), 32'(t_address0), DEPTH));
    assign t_idx1 = IdxWidth'(bank_addr(32'(tptr_q), 32'(t_address1), DEPTH));

    pp_chan_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ENTRIES    (Entries),
        .IDX_WIDTH  (IdxWidth)
    ) u_mem (
        .clk_i   (ap_clk),
        .rst_i   (ap_rst),
        .a_idx_i (i_idx),
        .a_ce_i  (i_ce0),
        .a_we_i  (i_we0),
        .a_d_i   (i_d0),
        .a_q_o   (i_q0),
        .b_idx_i (t_idx0),
        .b_ce_i  (t_ce0),
        .b_q_o   (t_q0),
        .c_idx_i (t_idx1),
        .c_ce_i  (t_ce1),
        .c_q_o   (t_q1)
    );

endmodule

// File: tb/tb_pp_chan_nbuf.sv
// Directed bench for pp_chan_nbuf (3 banks) with a per-cycle reference model and literal checks.
module tb_pp_chan_nbuf;

    localparam int NB = 3;
    localparam int DW = 32;
    localparam int DP = 16;
    localparam int AW = 4;
    localparam int CW = 2;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic [AW-1:0] i_address0 = '0;
    logic          i_ce0 = 1'b0;
    logic          i_we0 = 1'b0;
    logic [DW-1:0] i_d0 = '0;
    logic [DW-1:0] i_q0;
    logic          i_write = 1'b0;
    logic          i_full_n;
    logic [AW-1:0] t_address0 = '0;
    logic          t_ce0 = 1'b0;
    logic [AW-1:0] t_address1 = '0;
    logic          t_ce1 = 1'b0;
    logic [DW-1:0] t_q0;
    logic [DW-1:0] t_q1;
    logic          t_read = 1'b0;
    logic          t_empty_n;
    logic [CW-1:0] occupancy;
`ifdef PP_CHAN_ERR_EN
    logic          err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 ap_clk = ~ap_clk;

    pp_chan_nbuf #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .ADDR_WIDTH (AW),
        .NUM_BUFS   (NB)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .i_address0 (i_address0),
        .i_ce0      (i_ce0),
        .i_we0      (i_we0),
        .i_d0       (i_d0),
        .i_q0       (i_q0),
        .i_write    (i_write),
        .i_full_n   (i_full_n),
        .t_address0 (t_address0),
        .t_ce0      (t_ce0),
        .t_address1 (t_address1),
        .t_ce1      (t_ce1),
        .t_q0       (t_q0),
        .t_q1       (t_q1),
        .t_read     (t_read),
        .t_empty_n  (t_empty_n),
        .occupancy  (occupancy)
`ifdef PP_CHAN_ERR_EN
        ,
        .err        (err)
`endif
    );

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: committed banks form a ring of NB frames; words tracked with validity.
    int m_mem [NB][DP];
    bit m_val [NB][DP];
    int m_wr = 0;
    int m_rd = 0;
    int m_cnt = 0;
    int m_err = 0;
    int e_iq = 0, e_tq0 = 0, e_tq1 = 0;
    bit v_iq = 1, v_tq0 = 1, v_tq1 = 1;

    always @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            m_wr = 0; m_rd = 0; m_cnt = 0; m_err = 0;
            e_iq = 0; e_tq0 = 0; e_tq1 = 0;
            v_iq = 1; v_tq0 = 1; v_tq1 = 1;
        end else begin
            bit c, r;
            if (t_ce0) begin
                e_tq0 = m_mem[m_rd][t_address0]; v_tq0 = m_val[m_rd][t_address0];
            end
            if (t_ce1) begin
                e_tq1 = m_mem[m_rd][t_address1]; v_tq1 = m_val[m_rd][t_address1];
            end
            if (i_ce0) begin
                e_iq = m_mem[m_wr][i_address0]; v_iq = m_val[m_wr][i_address0];
                if (i_we0) begin
                    m_mem[m_wr][i_address0] = int'(i_d0);
                    m_val[m_wr][i_address0] = 1'b1;
                end
            end
            c = i_write && (m_cnt < NB);
            r = t_read && (m_cnt > 0);
            if ((i_write && !c) || (t_read && !r)) m_err = 1;
            if (c) m_wr = (m_wr + 1) % NB;
            if (r) m_rd = (m_rd + 1) % NB;
            m_cnt = m_cnt + int'(c) - int'(r);
        end
    end

    always @(negedge ap_clk) begin
        if (!ap_rst) begin
            check("cyc_full_n", {31'd0, i_full_n}, (m_cnt != NB) ? 1 : 0);
            check("cyc_empty_n", {31'd0, t_empty_n}, (m_cnt != 0) ? 1 : 0);
            check("cyc_occupancy", {30'd0, occupancy}, m_cnt);
            if (v_iq) check("cyc_i_q0", i_q0, e_iq);
            if (v_tq0) check("cyc_t_q0", t_q0, e_tq0);
            if (v_tq1) check("cyc_t_q1", t_q1, e_tq1);
`ifdef PP_CHAN_ERR_EN
            check("cyc_err", {31'd0, err}, m_err);
`endif
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #2;
    endtask

    task automatic wr(input int a, input int d);
        i_address0 = AW'(a); i_d0 = DW'(d); i_ce0 = 1'b1; i_we0 = 1'b1;
        step();
        i_ce0 = 1'b0; i_we0 = 1'b0;
    endtask

    task automatic commit();
        i_write = 1'b1; step(); i_write = 1'b0;
    endtask

    task automatic release_bank();
        t_read = 1'b1; step(); t_read = 1'b0;
    endtask

    task automatic rd(input int a0, input int a1);
        t_address0 = AW'(a0); t_address1 = AW'(a1); t_ce0 = 1'b1; t_ce1 = 1'b1;
        step();
        t_ce0 = 1'b0; t_ce1 = 1'b0;
    endtask

    task automatic frame(input int base);
        for (int a = 0; a < DP; a++) wr(a, base + a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge ap_clk);
        #2 ap_rst = 1'b0;
        step();
        check("reset_occupancy", {30'd0, occupancy}, 0);
        check("reset_full_n", {31'd0, i_full_n}, 1);
        check("reset_empty_n", {31'd0, t_empty_n}, 0);

        // Single frame into bank 0.
        frame(100);
        commit();
        check("commit_visible", {31'd0, t_empty_n}, 1);
        rd(3, 15);
        check("frame_t_q0", t_q0, 103);
        check("frame_t_q1", t_q1, 115);
        release_bank();
        check("drain_empty", {31'd0, t_empty_n}, 0);

        // Fill all three banks (1, 2, 0).
        frame(200); commit();
        frame(300); commit();
        frame(400); commit();
        check("full_occupancy", {30'd0, occupancy}, 3);
        check("full_full_n", {31'd0, i_full_n}, 0);
        commit();
        check("drop_occupancy", {30'd0, occupancy}, 3);
`ifdef PP_CHAN_ERR_EN
        check("drop_err", {31'd0, err}, 1);
`endif
        rd(0, 5);
        check("fifo0_q0", t_q0, 200);
        check("fifo0_q1", t_q1, 205);
        release_bank();
        rd(9, 9);
        check("fifo1_q0", t_q0, 309);
        release_bank();

        // Simultaneous commit and release at occupancy 1.
        frame(500);
        i_write = 1'b1; t_read = 1'b1; step(); i_write = 1'b0; t_read = 1'b0;
        check("simul_occupancy", {30'd0, occupancy}, 1);
        rd(2, 7);
        check("simul_q0", t_q0, 502);
        check("simul_q1", t_q1, 507);
        release_bank();
        release_bank();
        check("empty_drop_occ", {30'd0, occupancy}, 0);

        // Producer read-before-write in bank 2 (previously frame 300).
        wr(0, 999);
        check("rbw_old", i_q0, 300);
        i_address0 = '0; i_ce0 = 1'b1; step(); i_ce0 = 1'b0;
        check("rbw_new", i_q0, 999);

        // Seven tagged frames through the ring, keeping up to three in flight.
        wr(0, 1000); wr(15, 2000); commit();
        wr(0, 1001); wr(15, 2001); commit();
        for (int k = 2; k < 7; k++) begin
            wr(0, 1000 + k); wr(15, 2000 + k); commit();
            rd(0, 15);
            check("wrap_tag", t_q0, DW'(1000 + k - 2));
            check("wrap_tail", t_q1, DW'(2000 + k - 2));
            release_bank();
        end
        for (int k = 5; k < 7; k++) begin
            rd(0, 15);
            check("wrap_tag", t_q0, DW'(1000 + k));
            release_bank();
        end

        // Reset mid-operation with two committed banks (0 and 1).
        wr(0, 700); commit();
        wr(0, 701); commit();
        check("pre_reset_occ", {30'd0, occupancy}, 2);
        ap_rst = 1'b1;
        #1;
        check("midrst_empty_n", {31'd0, t_empty_n}, 0);
        check("midrst_full_n", {31'd0, i_full_n}, 1);
        check("midrst_occupancy", {30'd0, occupancy}, 0);
        check("midrst_t_q0", t_q0, 0);
        step();
        ap_rst = 1'b0;
        step();
        i_address0 = '0; i_ce0 = 1'b1; step(); i_ce0 = 1'b0;
        check("post_rst_bank0", i_q0, 700);
        wr(0, 800); commit();
        rd(0, 0);
        check("post_rst_frame", t_q0, 800);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
